// File: rtl/branch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_pkg : shared branch condition codes, FSM state encoding, counter init
// Rev 1.0
// ---------------------------------------------------------------------------
package branch_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_EQ   = 3'd1;
  localparam logic [2:0] BR_NE   = 3'd2;
  localparam logic [2:0] BR_GE   = 3'd3;
  localparam logic [2:0] BR_GT   = 3'd4;
  localparam logic [2:0] BR_LE   = 3'd5;
  localparam logic [2:0] BR_LT   = 3'd6;
  localparam logic [2:0] BR_RSVD = 3'd7;

  typedef enum logic [0:0] {
    FSM_IDLE  = 1'b0,
    FSM_FLUSH = 1'b1
  } fsm_e;

  localparam logic [1:0] CTR_INIT = 2'b01;

  function automatic logic br_eval(input logic [2:0] code, input logic zero, input logic sign);
    logic taken;
    taken = 1'b0;
    case (code)
      BR_EQ:   taken = zero;
      BR_NE:   taken = ~zero;
      BR_GE:   taken = ~sign | zero;
      BR_GT:   taken = ~sign & ~zero;
      BR_LE:   taken = sign | zero;
      BR_LT:   taken = sign;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predict_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_predict_ctrl_if : pipeline-facing signals of the branch predictor
// Rev 1.0
// ---------------------------------------------------------------------------
interface branch_predict_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             if_valid_i;
  logic [PC_W-1:0]  if_pc_i;
  logic             pred_taken_o;
  logic [PC_W-1:0]  pred_pc_o;
  logic             ex_valid_i;
  logic [2:0]       ex_branch_i;
  logic             ex_zero_i;
  logic             ex_sign_i;
  logic [PC_W-1:0]  ex_pc_i;
  logic [PC_W-1:0]  ex_target_i;
  logic             ex_pred_taken_i;
  logic [PC_W-1:0]  ex_pred_pc_i;
  logic             stall_i;
  logic             redirect_o;
  logic [PC_W-1:0]  redirect_pc_o;
  logic             flush_o;
  logic [CNT_W-1:0] br_count_o;
  logic [CNT_W-1:0] mis_count_o;

  modport master (
    output if_valid_i, if_pc_i, ex_valid_i, ex_branch_i, ex_zero_i, ex_sign_i,
           ex_pc_i, ex_target_i, ex_pred_taken_i, ex_pred_pc_i, stall_i,
    input  pred_taken_o, pred_pc_o, redirect_o, redirect_pc_o, flush_o,
           br_count_o, mis_count_o
  );

  modport slave (
    input  if_valid_i, if_pc_i, ex_valid_i, ex_branch_i, ex_zero_i, ex_sign_i,
           ex_pc_i, ex_target_i, ex_pred_taken_i, ex_pred_pc_i, stall_i,
    output pred_taken_o, pred_pc_o, redirect_o, redirect_pc_o, flush_o,
           br_count_o, mis_count_o
  );
endinterface
`default_nettype wire

// File: rtl/branch_predict_ctrl_bp_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bp_table : flop-based direct-mapped table of 2-bit counters and targets
// Rev 1.0
// ---------------------------------------------------------------------------
module bp_table
  import branch_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [IDX_W-1:0] i_rd_idx,
  output logic                  o_rd_valid,
  output logic [1:0]            o_rd_ctr,
  output logic [PC_W-1:0]       o_rd_target,
  input  wire logic             i_wr_en,
  input  wire logic [IDX_W-1:0] i_wr_idx,
  input  wire logic             i_wr_taken,
  input  wire logic [PC_W-1:0]  i_wr_target
);
  localparam int ENTRIES = 2 ** IDX_W;

  logic            r_valid  [ENTRIES];
  logic [1:0]      r_ctr    [ENTRIES];
  logic [PC_W-1:0] r_target [ENTRIES];

  assign o_rd_valid  = r_valid[i_rd_idx];
  assign o_rd_ctr    = r_ctr[i_rd_idx];
  assign o_rd_target = r_target[i_rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_ctr[i]    <= CTR_INIT;
        r_target[i] <= '0;
      end
    end else if (i_wr_en) begin
      if (i_wr_taken) begin
        if (r_ctr[i_wr_idx] != 2'b11) r_ctr[i_wr_idx] <= r_ctr[i_wr_idx] + 2'd1;
        r_valid[i_wr_idx]  <= 1'b1;
        r_target[i_wr_idx] <= i_wr_target;
      end else if (r_ctr[i_wr_idx] != 2'b00) begin
        r_ctr[i_wr_idx] <= r_ctr[i_wr_idx] - 2'd1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_predict_ctrl : IF-stage prediction, EX-stage resolve, redirect/flush
// Rev 1.0
// ---------------------------------------------------------------------------
module branch_predict_ctrl
  import branch_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int IDX_W        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  branch_predict_ctrl_if.slave bus
);
  localparam logic [0:0] ST_IDLE  = FSM_IDLE;
  localparam logic [0:0] ST_FLUSH = FSM_FLUSH;
  localparam logic [2:0] C_FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [PC_W-1:0] C_PC_STEP = PC_W'(4);

  logic [0:0]       r_state;
  logic [2:0]       r_fcnt;
  logic             r_redirect;
  logic [PC_W-1:0]  r_redirect_pc;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_mis_count;

  logic             w_rd_valid;
  logic [1:0]       w_rd_ctr;
  logic [PC_W-1:0]  w_rd_target;
  logic             w_pred_taken;
  logic             w_actual;
  logic             w_resolve;
  logic             w_mispredict;

  bp_table #(.PC_W(PC_W), .IDX_W(IDX_W)) u_table (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx    (bus.if_pc_i[IDX_W+1:2]),
    .o_rd_valid  (w_rd_valid),
    .o_rd_ctr    (w_rd_ctr),
    .o_rd_target (w_rd_target),
    .i_wr_en     (w_resolve),
    .i_wr_idx    (bus.ex_pc_i[IDX_W+1:2]),
    .i_wr_taken  (w_actual),
    .i_wr_target (bus.ex_target_i)
  );

  assign w_pred_taken     = bus.if_valid_i & w_rd_valid & w_rd_ctr[1];
  assign bus.pred_taken_o = w_pred_taken;
  assign bus.pred_pc_o    = w_pred_taken ? w_rd_target : bus.if_pc_i + C_PC_STEP;

  assign w_actual  = br_eval(bus.ex_branch_i, bus.ex_zero_i, bus.ex_sign_i);
  // Work sitting in EX while flushing is wrong-path and must not train or count.
  assign w_resolve = bus.ex_valid_i & ~bus.stall_i & (bus.ex_branch_i != BR_NONE) &
                     (r_state == ST_IDLE);
  assign w_mispredict = w_resolve &
                        ((w_actual != bus.ex_pred_taken_i) |
                         (w_actual & (bus.ex_pred_pc_i != bus.ex_target_i)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_fcnt        <= 3'd0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_br_count    <= '0;
      r_mis_count   <= '0;
    end else begin
      r_redirect <= w_mispredict;
      if (w_mispredict)
        r_redirect_pc <= w_actual ? bus.ex_target_i : bus.ex_pc_i + C_PC_STEP;

      case (r_state)
        ST_IDLE: begin
          if (w_mispredict) begin
            r_state <= ST_FLUSH;
            r_fcnt  <= C_FLUSH_INIT;
          end
        end
        ST_FLUSH: begin
          if (!bus.stall_i) begin
            r_fcnt <= r_fcnt - 3'd1;
            if (r_fcnt == 3'd1) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_resolve && (r_br_count != {CNT_W{1'b1}}))
        r_br_count <= r_br_count + 1'b1;
      if (w_mispredict && (r_mis_count != {CNT_W{1'b1}}))
        r_mis_count <= r_mis_count + 1'b1;
    end
  end

  assign bus.redirect_o    = r_redirect;
  assign bus.redirect_pc_o = r_redirect_pc;
  assign bus.flush_o       = (r_state == ST_FLUSH);
  assign bus.br_count_o    = r_br_count;
  assign bus.mis_count_o   = r_mis_count;
endmodule
`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_branch_predict_ctrl : scoreboard bench with an independent behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_branch_predict_ctrl;
  localparam int PC_W  = 32;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic             redir;
    logic [PC_W-1:0]  rpc;
    logic             flush;
    logic [CNT_W-1:0] br;
    logic [CNT_W-1:0] mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_predict_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_predict_ctrl #(.PC_W(PC_W), .IDX_W(4), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q_exp[$];

  logic             m_valid  [16];
  logic [1:0]       m_ctr    [16];
  logic [PC_W-1:0]  m_target [16];
  logic             m_flush;
  int               m_fcnt;
  logic [PC_W-1:0]  m_rpc;
  logic [CNT_W-1:0] m_br;
  logic [CNT_W-1:0] m_mis;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_taken(input logic [2:0] c, input logic z, input logic s);
    case (c)
      3'd1: return z;
      3'd2: return !z;
      3'd3: return !s || z;
      3'd4: return !s && !z;
      3'd5: return s || z;
      3'd6: return s;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_ctr[i] = 2'd1; m_target[i] = '0;
    end
    m_flush = 1'b0; m_fcnt = 0; m_rpc = '0; m_br = '0; m_mis = '0;
  endtask

  // One clock: check comb prediction, predict the registered outputs, compare after the edge.
  task automatic step();
    int   ii, ei;
    logic act, res, mis, ept;
    exp_t e, got;
    #1;
    ii  = int'(bus.if_pc_i[5:2]);
    ept = bus.if_valid_i && m_valid[ii] && m_ctr[ii][1];
    chk("pred_taken", 64'(bus.pred_taken_o), 64'(ept));
    chk("pred_pc", 64'(bus.pred_pc_o), 64'(ept ? m_target[ii] : bus.if_pc_i + 32'd4));

    ei  = int'(bus.ex_pc_i[5:2]);
    act = cond_taken(bus.ex_branch_i, bus.ex_zero_i, bus.ex_sign_i);
    res = bus.ex_valid_i && !bus.stall_i && bus.ex_branch_i != 3'd0 && !m_flush;
    mis = res && ((act != bus.ex_pred_taken_i) || (act && bus.ex_pred_pc_i != bus.ex_target_i));
    if (mis) m_rpc = act ? bus.ex_target_i : bus.ex_pc_i + 32'd4;
    if (m_flush) begin
      if (!bus.stall_i) begin
        m_fcnt--;
        if (m_fcnt == 0) m_flush = 1'b0;
      end
    end else if (mis) begin
      m_flush = 1'b1; m_fcnt = 2;
    end
    if (res) begin
      if (m_br != '1) m_br++;
      if (act) begin
        if (m_ctr[ei] < 2'd3) m_ctr[ei]++;
        m_valid[ei] = 1'b1; m_target[ei] = bus.ex_target_i;
      end else if (m_ctr[ei] > 2'd0) m_ctr[ei]--;
    end
    if (mis && m_mis != '1) m_mis++;
    q_exp.push_back('{redir: mis, rpc: m_rpc, flush: m_flush, br: m_br, mis: m_mis});

    @(posedge clk);
    #1;
    e = q_exp.pop_front();
    got = '{redir: bus.redirect_o, rpc: bus.redirect_pc_o, flush: bus.flush_o,
            br: bus.br_count_o, mis: bus.mis_count_o};
    chk("redirect", 64'(got.redir), 64'(e.redir));
    chk("redirect_pc", 64'(got.rpc), 64'(e.rpc));
    chk("flush", 64'(got.flush), 64'(e.flush));
    chk("br_count", 64'(got.br), 64'(e.br));
    chk("mis_count", 64'(got.mis), 64'(e.mis));
    @(negedge clk);
  endtask

  task automatic ex_branch(input logic [2:0] code, input logic z, input logic s,
                           input logic [31:0] pc, input logic [31:0] tgt,
                           input logic ppt, input logic [31:0] ppc);
    bus.ex_valid_i = 1'b1; bus.ex_branch_i = code; bus.ex_zero_i = z; bus.ex_sign_i = s;
    bus.ex_pc_i = pc; bus.ex_target_i = tgt; bus.ex_pred_taken_i = ppt; bus.ex_pred_pc_i = ppc;
    step();
    bus.ex_valid_i = 1'b0; bus.ex_branch_i = 3'd0;
  endtask

  task automatic drain();
    int n = 0;
    while (m_flush && n < 20) begin
      step();
      n++;
    end
    chk("drain_bound", 64'(m_flush), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_flush", 64'(bus.flush_o), 64'd0);
    chk("rst_redirect", 64'(bus.redirect_o), 64'd0);
    chk("rst_rpc", 64'(bus.redirect_pc_o), 64'd0);
    chk("rst_br", 64'(bus.br_count_o), 64'd0);
    chk("rst_mis", 64'(bus.mis_count_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.if_valid_i = 1'b1; bus.if_pc_i = 32'h40;
    bus.ex_valid_i = 1'b0; bus.ex_branch_i = 3'd0; bus.ex_zero_i = 1'b0; bus.ex_sign_i = 1'b0;
    bus.ex_pc_i = '0; bus.ex_target_i = '0; bus.ex_pred_taken_i = 1'b0; bus.ex_pred_pc_i = '0;
    bus.stall_i = 1'b0;
    @(negedge clk);
    do_reset();
    step();

    ex_branch(3'd1, 1'b1, 1'b0, 32'h40, 32'h80, 1'b0, 32'h44);
    drain();
    step();
    chk("trained_taken", 64'(bus.pred_taken_o), 64'd1);
    chk("trained_pc", 64'(bus.pred_pc_o), 64'h80);

    bus.if_pc_i = 32'h50;
    ex_branch(3'd2, 1'b1, 1'b0, 32'h50, 32'hA0, 1'b0, 32'h54);
    ex_branch(3'd2, 1'b1, 1'b0, 32'h50, 32'hA0, 1'b0, 32'h54);
    ex_branch(3'd1, 1'b1, 1'b0, 32'h50, 32'hA0, 1'b0, 32'h54);
    drain();
    step();

    bus.if_pc_i = 32'h70;
    ex_branch(3'd2, 1'b0, 1'b0, 32'h70, 32'hC0, 1'b0, 32'h74);
    bus.stall_i = 1'b1;
    step();
    ex_branch(3'd1, 1'b1, 1'b0, 32'h70, 32'hD0, 1'b0, 32'h74);
    bus.stall_i = 1'b0;
    ex_branch(3'd1, 1'b1, 1'b0, 32'h70, 32'hD0, 1'b0, 32'h74);
    bus.stall_i = 1'b1;
    step();
    bus.stall_i = 1'b0;
    drain();
    step();

    ex_branch(3'd1, 1'b1, 1'b0, 32'h40, 32'h80, 1'b1, 32'h90);
    drain();

    for (int c = 3; c <= 6; c++) begin
      for (int f = 0; f < 4; f++) begin
        bus.if_pc_i = 32'(32'h100 + c * 4);
        ex_branch(3'(c), f[0], f[1], 32'(32'h100 + c * 4), 32'(32'h200 + f * 16), 1'b0, 32'h0);
        drain();
      end
    end

    ex_branch(3'd4, 1'b0, 1'b0, 32'h40, 32'h88, 1'b0, 32'h44);
    chk("pre_rst_flush", 64'(bus.flush_o), 64'd1);
    do_reset();
    bus.if_pc_i = 32'h40;
    step();
    ex_branch(3'd7, 1'b1, 1'b1, 32'h48, 32'hF0, 1'b0, 32'h4C);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
